// File: rtl/ram_port_arbiter_if.sv
// Requester-side handshake and RAM-side bus of the shared message-buffer port.
// slave = arbiter view, master = requesters plus RAM view.
interface ram_port_arbiter_if #(
   parameter int NUM_REQ    = 4,
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 32
);
   logic [NUM_REQ-1:0]            req_valid;
   logic [NUM_REQ-1:0]            req_we;
   logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
   logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata;
   logic [NUM_REQ-1:0]            req_ready;
   logic [NUM_REQ-1:0]            rsp_valid;
   logic [DATA_WIDTH-1:0]         rsp_rdata;
   logic [ADDR_WIDTH-1:0]         ram_addr;
   logic [DATA_WIDTH-1:0]         ram_wdata;
   logic                          ram_cs;
   logic                          ram_we;
   logic                          ram_oe;
   logic [DATA_WIDTH-1:0]         ram_rdata;

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, ram_rdata,
      output req_ready, rsp_valid, rsp_rdata, ram_addr, ram_wdata, ram_cs, ram_we, ram_oe
   );

   modport master (
      output req_valid, req_we, req_addr, req_wdata, ram_rdata,
      input  req_ready, rsp_valid, rsp_rdata, ram_addr, ram_wdata, ram_cs, ram_we, ram_oe
   );
endinterface

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one registered-read RAM port among NUM_REQ requesters.
// Writes take one RAM cycle; reads take two (address + output hold) plus a response cycle.
module ram_port_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 32
) (
   input  logic                clk,
   input  logic                rst_n,
   ram_port_arbiter_if.slave   bus
);
   localparam int IDXW = $clog2(NUM_REQ);
   localparam int IW1  = IDXW + 1;

   typedef enum logic [1:0] {IDLE, WR, RD, RD_HOLD} state_e;

   state_e                                 state_q, state_d;
   logic [IDXW-1:0]                        rr_last_q, rr_last_d;
   logic [IDXW-1:0]                        win_q, win_d;
   logic [IDXW-1:0]                        gnt_idx;
   logic                                   gnt_found;
   logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]     addr_a;
   logic [NUM_REQ-1:0][DATA_WIDTH-1:0]     wdata_a;
   logic [NUM_REQ-1:0]                     ready_d;
   logic [NUM_REQ-1:0]                     rsp_valid_q, rsp_valid_d;
   logic [DATA_WIDTH-1:0]                  rsp_rdata_q, rsp_rdata_d;
   logic [ADDR_WIDTH-1:0]                  ram_addr_q, ram_addr_d;
   logic [DATA_WIDTH-1:0]                  ram_wdata_q, ram_wdata_d;
   logic                                   cs_q, cs_d, we_q, we_d, oe_q, oe_d;

   assign addr_a  = bus.req_addr;
   assign wdata_a = bus.req_wdata;

   // Scan rr_last+1 .. rr_last+NUM_REQ with an explicit wrap so odd NUM_REQ works.
   always_comb begin : rr_pick
      logic [IW1-1:0] cand;
      gnt_found = 1'b0;
      gnt_idx   = '0;
      cand      = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         cand = {1'b0, rr_last_q} + IW1'(k);
         if (cand >= IW1'(NUM_REQ)) cand = cand - IW1'(NUM_REQ);
         if (!gnt_found && bus.req_valid[cand[IDXW-1:0]]) begin
            gnt_found = 1'b1;
            gnt_idx   = cand[IDXW-1:0];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d     = state_q;
      rr_last_d   = rr_last_q;
      win_d       = win_q;
      ready_d     = '0;
      rsp_valid_d = '0;
      rsp_rdata_d = rsp_rdata_q;
      ram_addr_d  = ram_addr_q;
      ram_wdata_d = ram_wdata_q;
      cs_d        = 1'b0;
      we_d        = 1'b0;
      oe_d        = 1'b0;
      case (state_q)
         IDLE: begin
            if (gnt_found) begin
               ready_d[gnt_idx] = 1'b1;
               rr_last_d        = gnt_idx;
               win_d            = gnt_idx;
               ram_addr_d       = addr_a[gnt_idx];
               ram_wdata_d      = wdata_a[gnt_idx];
               cs_d             = 1'b1;
               we_d             = bus.req_we[gnt_idx];
               oe_d             = !bus.req_we[gnt_idx];
               state_d          = bus.req_we[gnt_idx] ? WR : RD;
            end
         end
         WR: state_d = IDLE;
         RD: begin
            // Keep cs/oe asserted through RD_HOLD so the RAM keeps driving its output.
            cs_d    = 1'b1;
            oe_d    = 1'b1;
            state_d = RD_HOLD;
         end
         RD_HOLD: begin
            rsp_rdata_d        = bus.ram_rdata;
            rsp_valid_d[win_q] = 1'b1;
            state_d            = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_last_q   <= IDXW'(NUM_REQ - 1);
         win_q       <= '0;
         rsp_valid_q <= '0;
         rsp_rdata_q <= '0;
         ram_addr_q  <= '0;
         ram_wdata_q <= '0;
         cs_q        <= 1'b0;
         we_q        <= 1'b0;
         oe_q        <= 1'b0;
      end else begin
         rr_last_q   <= rr_last_d;
         win_q       <= win_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         ram_addr_q  <= ram_addr_d;
         ram_wdata_q <= ram_wdata_d;
         cs_q        <= cs_d;
         we_q        <= we_d;
         oe_q        <= oe_d;
      end
   end

   assign bus.req_ready = ready_d;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_rdata = rsp_rdata_q;
   assign bus.ram_addr  = ram_addr_q;
   assign bus.ram_wdata = ram_wdata_q;
   assign bus.ram_cs    = cs_q;
   assign bus.ram_we    = we_q;
   assign bus.ram_oe    = oe_q;
endmodule
